i2c_ball_slave_rx: RTL and testbench

- Responder end of the ball-state I2C link: bit-level I2C slave that receives the 6-byte write frame from the master-side controller.
- Frame layout: address byte, then 5 data bytes.
- Detects START/STOP, matches the address, ACKs each byte and reassembles ball_y, ball_vy, gravity_counter and safe_speed.
- Publishes the full set atomically, with a one-cycle valid pulse, only on a clean STOP. Feeds the slave-side game/ball logic.

---
 rtl/i2c_ball_slave_rx.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_ball_slave_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ball_slave_rx.sv
`timescale 1ns/1ps
// Bit-level I2C write-only slave that receives a 6-byte ball-state frame
// (address + 5 data bytes) and publishes it atomically on a clean STOP.
module i2c_ball_slave_rx #(
  parameter logic [7:0]  ADDR_BYTE = 8'hAA,
  parameter int unsigned NUM_DATA  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic [7:0] safe_speed,
  output logic       ball_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] state_led
);

  localparam int unsigned CW = $clog2(NUM_DATA + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DATA);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  logic          scl_s1, scl_s2, scl_prev;
  logic          sda_s1, sda_s2, sda_prev;
  logic          start_ev, stop_ev, scl_rise, scl_fall;

  logic [2:0]    state;
  logic [2:0]    bit_cnt;
  logic          byte_full;
  logic [7:0]    shifter;
  logic [CW-1:0] byte_cnt;
  logic          matched;
  logic          overflow;

  // Only the bits that reach the outputs are kept; reserved bits are dropped.
  logic [1:0]    sh_y_hi;
  logic [7:0]    sh_y_lo;
  logic [7:0]    sh_vy;
  logic [1:0]    sh_grav;
  logic [7:0]    sh_speed;

  // Synchronisers reset to the idle-bus level so reset release sees no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda_i;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  always_comb begin
    start_ev = scl_s2 &  sda_prev & ~sda_s2;
    stop_ev  = scl_s2 & ~sda_prev &  sda_s2;
    scl_rise =  scl_s2 & ~scl_prev;
    scl_fall = ~scl_s2 &  scl_prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      byte_full       <= 1'b0;
      shifter         <= '0;
      byte_cnt        <= '0;
      matched         <= 1'b0;
      overflow        <= 1'b0;
      sh_y_hi         <= '0;
      sh_y_lo         <= '0;
      sh_vy           <= '0;
      sh_grav         <= '0;
      sh_speed        <= '0;
      sda_oe          <= 1'b0;
      busy            <= 1'b0;
      ball_valid      <= 1'b0;
      frame_err       <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      safe_speed      <= '0;
    end else begin
      ball_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (start_ev) begin
        // A START inside an addressed frame aborts it without committing.
        if (state != ST_IDLE && matched)
          frame_err <= 1'b1;
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        byte_cnt  <= '0;
        matched   <= 1'b0;
        overflow  <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_ev) begin
        if (state != ST_IDLE) begin
          state   <= ST_IDLE;
          sda_oe  <= 1'b0;
          busy    <= 1'b0;
          matched <= 1'b0;
          if (matched) begin
            if (byte_cnt == LAST_CNT && !overflow) begin
              ball_y          <= {sh_y_hi, sh_y_lo};
              ball_vy         <= sh_vy;
              gravity_counter <= sh_grav;
              safe_speed      <= sh_speed;
              ball_valid      <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      end else begin
        if (scl_rise && (state == ST_ADDR || state == ST_DATA) && !byte_full) begin
          shifter <= {shifter[6:0], sda_s2};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            byte_full <= 1'b1;
        end
        if (scl_fall) begin
          case (state)
            ST_ADDR: begin
              if (byte_full) begin
                byte_full <= 1'b0;
                if (shifter == ADDR_BYTE) begin
                  sda_oe  <= 1'b1;
                  busy    <= 1'b1;
                  matched <= 1'b1;
                  state   <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
            ST_DATA: begin
              if (byte_full) begin
                byte_full <= 1'b0;
                if (byte_cnt < LAST_CNT) begin
                  case (byte_cnt)
                    CW'(0):  sh_y_hi  <= shifter[7:6];
                    CW'(1):  sh_y_lo  <= shifter;
                    CW'(2):  sh_vy    <= shifter;
                    CW'(3):  sh_grav  <= shifter[1:0];
                    CW'(4):  sh_speed <= shifter;
                    default: ;
                  endcase
                  byte_cnt <= byte_cnt + CW'(1);
                  sda_oe   <= 1'b1;
                  state    <= ST_DATA_ACK;
                end else begin
                  overflow <= 1'b1;
                  state    <= ST_IGNORE;
                end
              end
            end
            ST_IGNORE: sda_oe <= 1'b0;
            default:   ;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_led = '0;
    case (state)
      ST_ADDR:     state_led = 8'h01;
      ST_ADDR_ACK: state_led = 8'h02;
      ST_DATA:     state_led = 8'h04;
      ST_DATA_ACK: state_led = 8'h08;
      ST_IGNORE:   state_led = 8'h10;
      default:     state_led = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_i2c_ball_slave_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for i2c_ball_slave_rx: a bus-level master drives frames,
// a frame-level model predicts ACKs and commit/error pulses.
module tb_i2c_ball_slave_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_i;
  logic       sda_oe;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic [7:0] safe_speed;
  logic       ball_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] state_led;

  i2c_ball_slave_rx #(.ADDR_BYTE(8'hAA), .NUM_DATA(5)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .safe_speed(safe_speed), .ball_valid(ball_valid), .frame_err(frame_err),
    .busy(busy), .state_led(state_led)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and slave.
  always_comb sda_i = sda_m & ~sda_oe;

  typedef struct {
    bit         is_valid;
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] g;
    logic [7:0] s;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;

  logic [9:0] m_y;
  logic [7:0] m_vy;
  logic [1:0] m_g;
  logic [7:0] m_s;
  bit         open_matched;
  logic [7:0] fb [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_q();
    repeat (6) @(negedge clk);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_valid = 1'b0;
    e.y = '0; e.vy = '0; e.g = '0; e.s = '0;
    sbq.push_back(e);
  endtask

  task automatic bus_start();
    if (open_matched) push_err();
    open_matched = 1'b0;
    wait_q(); sda_m = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_q(); sda_m = b[i];
      wait_q(); scl = 1'b1;
      wait_q();
      wait_q(); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string name);
    send_bits(b);
    wait_q(); sda_m = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); chk(name, {31'd0, ~sda_i}, {31'd0, exp_ack});
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop(input int n);
    exp_t e;
    if (open_matched) begin
      if (n == 5) begin
        e.is_valid = 1'b1;
        e.y  = {fb[1][7:6], fb[2]};
        e.vy = fb[3];
        e.g  = fb[4][1:0];
        e.s  = fb[5];
        m_y = e.y; m_vy = e.vy; m_g = e.g; m_s = e.s;
        sbq.push_back(e);
      end else begin
        push_err();
      end
    end
    open_matched = 1'b0;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ball_y"},  {22'd0, ball_y}, {22'd0, m_y});
    chk({tag, "_ball_vy"}, {24'd0, ball_vy}, {24'd0, m_vy});
    chk({tag, "_grav"},    {30'd0, gravity_counter}, {30'd0, m_g});
    chk({tag, "_speed"},   {24'd0, safe_speed}, {24'd0, m_s});
  endtask

  // fb[0] is the address byte, fb[1..n] the data bytes.
  task automatic run_frame(input int n, input bit with_stop);
    bit matched;
    bus_start();
    matched = (fb[0] == 8'hAA);
    send_byte(fb[0], matched, "addr_ack");
    chk("busy_after_addr", {31'd0, busy}, {31'd0, matched});
    for (int i = 1; i <= n; i++)
      send_byte(fb[i], matched && (i <= 5), "data_ack");
    open_matched = matched;
    if (with_stop) begin
      bus_stop(n);
      chk("busy_after_stop", {31'd0, busy}, 32'd0);
      chk("led_after_stop", {24'd0, state_led}, 32'd0);
      check_outputs("post_stop");
    end
  endtask

  task automatic set_frame(input logic [7:0] a, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
    fb[0] = a; fb[1] = d1; fb[2] = d2; fb[3] = d3; fb[4] = d4; fb[5] = d5;
    fb[6] = 8'h5A; fb[7] = 8'hC3;
  endtask

  always @(negedge clk) begin
    if (!reset && (ball_valid || frame_err)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b want none at %0t",
                 ball_valid, frame_err, $time);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.is_valid) begin
          chk("valid_pulse", {30'd0, frame_err, ball_valid}, 32'b01);
          chk("ball_y",  {22'd0, ball_y}, {22'd0, mon_e.y});
          chk("ball_vy", {24'd0, ball_vy}, {24'd0, mon_e.vy});
          chk("grav",    {30'd0, gravity_counter}, {30'd0, mon_e.g});
          chk("speed",   {24'd0, safe_speed}, {24'd0, mon_e.s});
        end else begin
          chk("err_pulse", {30'd0, frame_err, ball_valid}, 32'b10);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    open_matched = 1'b0;
    m_y = '0; m_vy = '0; m_g = '0; m_s = '0;
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_led", {24'd0, state_led}, 32'd0);
    chk("rst_pulses", {30'd0, ball_valid, frame_err}, 32'd0);
    check_outputs("rst");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    set_frame(8'hAA, 8'h80, 8'hA5, 8'h3C, 8'h02, 8'h14);
    run_frame(5, 1'b1);
    chk("good_y_const", {22'd0, ball_y}, 32'h2A5);

    set_frame(8'hAC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    run_frame(5, 1'b1);

    set_frame(8'hAA, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04);
    run_frame(3, 1'b1);

    set_frame(8'hAA, 8'h40, 8'h10, 8'h20, 8'h01, 8'h30);
    run_frame(6, 1'b1);

    set_frame(8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(2, 1'b0);
    set_frame(8'hAA, 8'hC0, 8'hFF, 8'hFF, 8'h03, 8'h01);
    run_frame(5, 1'b1);
    chk("restart_y_const", {22'd0, ball_y}, 32'h3FF);

    // Reset during the ACK slot of the second data byte.
    bus_start();
    send_byte(8'hAA, 1'b1, "rst_addr_ack");
    send_byte(8'h12, 1'b1, "rst_d0_ack");
    send_bits(8'h34);
    wait_q(); sda_m = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q();
    chk("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    #1;
    m_y = '0; m_vy = '0; m_g = '0; m_s = '0;
    open_matched = 1'b0;
    chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    check_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    wait_q(); scl = 1'b0;
    bus_stop(0);
    check_outputs("after_reset");

    set_frame(8'hAA, 8'h40, 8'h77, 8'h9A, 8'h01, 8'h66);
    run_frame(5, 1'b1);

    for (int k = 0; k < 12; k++) begin
      int n;
      bit st;
      fb[0] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hAA;
      for (int j = 1; j < 8; j++) fb[j] = 8'($urandom);
      n  = $urandom_range(0, 7);
      st = (k == 11) || ($urandom_range(0, 3) != 0);
      run_frame(n, st);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    check_outputs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
